instmem_ctrl: RTL and testbench

//  Sequences and shares the single-port instruction memory between two requesters:
//  the CPU fetch stage (read-only) and a program loader (write-only).

---
 rtl/instmem_ctrl_pkg.sv | 14 +
 rtl/instmem_arb_starve.sv | 56 +++++
 rtl/instmem_ctrl.sv | 116 +++++++++++
 tb/tb_instmem_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instmem_ctrl_pkg.sv
// Shared types and defaults for the instruction-memory controller.
// The arbiter and the top both import this package.
package instmem_ctrl_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_BOOT = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/instmem_arb_starve.sv
// Grant decision for the shared instruction memory.
// Fetch has priority in RUN, and a starvation counter guarantees the loader a slot.
module instmem_arb_starve
    import instmem_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  state_e state_i,
    input  logic   f_req_i,
    input  logic   l_req_i,
    output logic   f_gnt_o,
    output logic   l_gnt_o
);

    localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          loader_wins;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        f_gnt_o     = 1'b0;
        l_gnt_o     = 1'b0;
        cnt_d       = cnt_q;
        loader_wins = (cnt_q == LIMIT) && l_req_i;
        case (state_i)
            ST_BOOT: begin
                l_gnt_o = l_req_i;
            end
            ST_RUN: begin
                f_gnt_o = f_req_i & ~loader_wins;
                l_gnt_o = l_req_i & ~f_gnt_o;
                if (l_gnt_o) begin
                    cnt_d = '0;
                end else if (l_req_i && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instmem_ctrl.sv
// Shares the single-port instruction memory between CPU fetch (read) and a program loader (write).
// Sequences preload -> optional boot load -> run; fetch data returns one cycle after grant.
module instmem_ctrl
    import instmem_ctrl_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int DEPTH        = 256,
    parameter int STARVE_LIMIT = 4,
    parameter bit BOOT_LOAD    = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [DW-1:0] f_data,
    output logic          f_err,
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_data,
    input  logic          l_done,
    output logic          l_gnt,
    output logic          cpu_stall,
    output logic          mem_init,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    input  logic [DW-1:0] mem_dataout
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_e        state_q;
    logic          mem_init_q;
    logic          run_q;
    logic          f_valid_q;
    logic          f_err_q;
    logic [DW-1:0] f_data_q;
    logic          f_oor;

    instmem_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .state_i (state_q),
        .f_req_i (f_req),
        .l_req_i (l_req),
        .f_gnt_o (f_gnt),
        .l_gnt_o (l_gnt)
    );

    // mem_init and the run flag are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            mem_init_q <= 1'b1;
            run_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    mem_init_q <= 1'b0;
                    if (BOOT_LOAD) begin
                        state_q <= ST_BOOT;
                    end else begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_BOOT: begin
                    if (l_done) begin
                        state_q <= ST_RUN;
                        run_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q    <= ST_INIT;
                    mem_init_q <= 1'b1;
                    run_q      <= 1'b0;
                end
            endcase
        end
    end

    assign f_oor      = (f_addr >= DEPTH_A);
    assign mem_datain = l_data;
    assign mem_addr   = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
    assign mem_write  = l_gnt & (l_addr < DEPTH_A);
    assign mem_init   = mem_init_q;
    assign cpu_stall  = ~run_q | (f_req & ~f_gnt);

    // Data and error hold their last value when no fetch was granted; only f_valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_valid_q <= 1'b0;
            f_err_q   <= 1'b0;
            f_data_q  <= '0;
        end else begin
            f_valid_q <= f_gnt;
            if (f_gnt) begin
                f_err_q  <= f_oor;
                f_data_q <= f_oor ? '0 : mem_dataout;
            end
        end
    end

    assign f_valid = f_valid_q;
    assign f_err   = f_err_q;
    assign f_data  = f_data_q;

endmodule

// File: tb/tb_instmem_ctrl.sv
// Directed bench for instmem_ctrl: a BOOT_LOAD=1 instance and a BOOT_LOAD=0 instance,
// each with a behavioural instmemory (sync preload/write, combinational read).
module tb_instmem_ctrl;
    import instmem_ctrl_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          f_req, l_req, l_done;
    logic [AW-1:0] f_addr, l_addr;
    logic [DW-1:0] l_data;
    logic          f_gnt, f_valid, f_err, l_gnt, cpu_stall, mem_init, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] f_data, mem_datain, mem_dataout;

    logic          b_f_req, b_l_req, b_l_done;
    logic [AW-1:0] b_f_addr, b_l_addr;
    logic [DW-1:0] b_l_data;
    logic          b_f_gnt, b_f_valid, b_f_err, b_l_gnt, b_cpu_stall, b_mem_init, b_mem_write;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_f_data, b_mem_datain, b_mem_dataout;

    instmem_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_LIMIT(4), .BOOT_LOAD(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_data(f_data), .f_err(f_err),
        .l_req(l_req), .l_addr(l_addr), .l_data(l_data), .l_done(l_done), .l_gnt(l_gnt),
        .cpu_stall(cpu_stall), .mem_init(mem_init), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    instmem_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .STARVE_LIMIT(4), .BOOT_LOAD(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .f_req(b_f_req), .f_addr(b_f_addr), .f_gnt(b_f_gnt), .f_valid(b_f_valid), .f_data(b_f_data),
        .f_err(b_f_err), .l_req(b_l_req), .l_addr(b_l_addr), .l_data(b_l_data), .l_done(b_l_done),
        .l_gnt(b_l_gnt), .cpu_stall(b_cpu_stall), .mem_init(b_mem_init), .mem_write(b_mem_write),
        .mem_addr(b_mem_addr), .mem_datain(b_mem_datain), .mem_dataout(b_mem_dataout)
    );

    function automatic logic [DW-1:0] preload(input int i);
        return 32'hC0DE_0000 | DW'(i);
    endfunction

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem_a[i] <= preload(i);
        end else if (mem_write) begin
            mem_a[mem_addr[7:0]] <= mem_datain;
        end
    end
    assign mem_dataout = (mem_addr < AW'(DEPTH)) ? mem_a[mem_addr[7:0]] : '1;

    always @(posedge clk) begin
        if (b_mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem_b[i] <= preload(i);
        end else if (b_mem_write) begin
            mem_b[b_mem_addr[7:0]] <= b_mem_datain;
        end
    end
    assign b_mem_dataout = (b_mem_addr < AW'(DEPTH)) ? mem_b[b_mem_addr[7:0]] : '1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        f_req = 1'b1; f_addr = 16'h0005;
        l_req = 1'b1; l_addr = 16'h0005; l_data = 32'hDEAD_BEEF; l_done = 1'b0;
        b_f_req = 1'b0; b_f_addr = '0; b_l_req = 1'b0; b_l_addr = '0; b_l_data = '0; b_l_done = 1'b0;

        // 1: reset held for three cycles, then one INIT cycle with the preload pulse
        repeat (3) tick();
        check("rst_f_gnt", f_gnt, 0);
        check("rst_l_gnt", l_gnt, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_f_valid", f_valid, 0);
        check("rst_f_data", f_data, 0);
        reset = 1'b1;
        #1;
        check("init_mem_init", mem_init, 1);
        check("init_cpu_stall", cpu_stall, 1);
        check("init_l_gnt", l_gnt, 0);
        tick();
        check("boot_state", dut_a.state_q, ST_BOOT);
        check("boot_mem_init", mem_init, 0);
        check("boot_cpu_stall", cpu_stall, 1);
        check("boot_f_gnt", f_gnt, 0);
        check("boot_l_gnt", l_gnt, 1);
        check("boot_mem_write", mem_write, 1);
        check("boot_mem_addr", mem_addr, 16'h0005);

        // 2: second write in the l_done cycle, then fetch back both words
        tick();
        l_addr = 16'h0006; l_data = 32'h1234_5678; l_done = 1'b1;
        #1;
        check("done_l_gnt", l_gnt, 1);
        check("done_mem_write", mem_write, 1);
        tick();
        l_req = 1'b0; l_done = 1'b0; f_addr = 16'h0005;
        #1;
        check("run_state", dut_a.state_q, ST_RUN);
        check("run_cpu_stall", cpu_stall, 0);
        check("run_f_gnt", f_gnt, 1);
        check("run_mem_addr", mem_addr, 16'h0005);
        tick();
        check("fetch5_valid", f_valid, 1);
        check("fetch5_data", f_data, 32'hDEAD_BEEF);
        check("fetch5_err", f_err, 0);
        f_addr = 16'h0006;
        tick();
        check("fetch6_valid", f_valid, 1);
        check("fetch6_data", f_data, 32'h1234_5678);
        f_req = 1'b0;
        #1;
        check("idle_cpu_stall", cpu_stall, 0);
        check("idle_f_gnt", f_gnt, 0);
        tick();
        check("idle_f_valid", f_valid, 0);
        check("idle_f_data_hold", f_data, 32'h1234_5678);

        // 3: loader starved for four cycles, wins the fifth
        f_req = 1'b1; f_addr = 16'h0005;
        l_req = 1'b1; l_addr = 16'h0007; l_data = 32'hAAAA_5555;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("starve%0d_l_gnt", i), l_gnt, 0);
            check($sformatf("starve%0d_f_gnt", i), f_gnt, 1);
            tick();
        end
        check("win_l_gnt", l_gnt, 1);
        check("win_f_gnt", f_gnt, 0);
        check("win_cpu_stall", cpu_stall, 1);
        check("win_mem_write", mem_write, 1);
        check("win_mem_addr", mem_addr, 16'h0007);
        tick();
        check("win_cnt_clear", dut_a.u_arb.cnt_q, 0);
        check("win_f_valid", f_valid, 0);
        check("after_f_gnt", f_gnt, 1);
        check("after_l_gnt", l_gnt, 0);
        l_req = 1'b0; f_addr = 16'h0007;
        tick();
        check("fetch7_valid", f_valid, 1);
        check("fetch7_data", f_data, 32'hAAAA_5555);

        // 4: out-of-range fetch and suppressed out-of-range write
        f_addr = 16'h0100;
        tick();
        check("oor_f_valid", f_valid, 1);
        check("oor_f_err", f_err, 1);
        check("oor_f_data", f_data, 0);
        f_req = 1'b0; l_req = 1'b1; l_addr = 16'h0100; l_data = 32'hFFFF_0000;
        #1;
        check("oor_l_gnt", l_gnt, 1);
        check("oor_mem_write", mem_write, 0);
        tick();
        l_req = 1'b0; f_req = 1'b1; f_addr = 16'h0000;
        tick();
        check("fetch0_data", f_data, preload(0));
        check("fetch0_err", f_err, 0);

        // 5: asynchronous reset with a fetch return in flight
        f_addr = 16'h0005;
        tick();
        check("pre_rst_f_valid", f_valid, 1);
        reset = 1'b0;
        #1;
        check("async_f_valid", f_valid, 0);
        check("async_mem_init", mem_init, 1);
        check("async_f_gnt", f_gnt, 0);
        check("async_state", dut_a.state_q, ST_INIT);
        tick();
        reset = 1'b1;
        #1;
        check("reinit_mem_init", mem_init, 1);
        check("b_init_mem_init", b_mem_init, 1);
        check("b_init_cpu_stall", b_cpu_stall, 1);
        tick();
        check("reboot_state", dut_a.state_q, ST_BOOT);

        // 6: BOOT_LOAD=0 instance goes straight to RUN and reads the preload
        check("b_run_state", dut_b.state_q, ST_RUN);
        b_f_req = 1'b1; b_f_addr = 16'h0000;
        #1;
        check("b_f_gnt", b_f_gnt, 1);
        check("b_cpu_stall", b_cpu_stall, 0);
        tick();
        check("b_f_valid", b_f_valid, 1);
        check("b_f_data", b_f_data, preload(0));
        b_f_req = 1'b0; f_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
